// File: rtl/rf_wb_arbiter_if.sv
// Bundle for rf_wb_arbiter: the two writeback requesters, the decode issue port
// and the register-file write port.
interface rf_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wd;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_is_load;
    logic        issue_stall;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    modport master (
        output alu_valid, alu_rd, alu_wd,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_wd,
        input  lsu_ready,
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_load,
        input  issue_stall,
        input  rf_we, rf_a3, rf_wd3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_wd,
        output lsu_ready,
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_load,
        output issue_stall,
        output rf_we, rf_a3, rf_wd3
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: round-robin ALU/LSU writeback arbitration with a
// registered write stage and a load-busy scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_arbiter #(
    parameter bit LSU_FIRST = 1'b1,
    parameter bit SB_EN     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);

    logic        gnt_alu_s;
    logic        gnt_lsu_s;
    logic [4:0]  win_rd_s;
    logic [31:0] win_wd_s;
    logic        stall_s;
    logic        accept_s;
    logic [31:0] clr_mask_s;
    logic [31:0] set_mask_s;
    logic [31:0] busy_nxt_s;

    logic        ptr_r;      // 1: LSU wins the next tie
    logic        rf_we_r;
    logic [4:0]  rf_a3_r;
    logic [31:0] rf_wd3_r;
    logic        src_lsu_r;
    logic [31:0] busy_r;

    function automatic logic reg_busy(input logic [31:0] busy, input logic [4:0] idx);
        return (idx != 5'd0) && busy[idx];
    endfunction

    // Round-robin grant between the two writeback sources
    always_comb begin
        gnt_alu_s = 1'b0;
        gnt_lsu_s = 1'b0;
        if (bus.alu_valid && bus.lsu_valid) begin
            if (ptr_r) begin
                gnt_lsu_s = 1'b1;
            end else begin
                gnt_alu_s = 1'b1;
            end
        end else if (bus.alu_valid) begin
            gnt_alu_s = 1'b1;
        end else if (bus.lsu_valid) begin
            gnt_lsu_s = 1'b1;
        end else begin
            gnt_alu_s = 1'b0;
            gnt_lsu_s = 1'b0;
        end
    end

    // Select the granted source's destination and data
    always_comb begin
        win_rd_s = 5'd0;
        win_wd_s = 32'd0;
        if (gnt_lsu_s) begin
            win_rd_s = bus.lsu_rd;
            win_wd_s = bus.lsu_wd;
        end else begin
            win_rd_s = bus.alu_rd;
            win_wd_s = bus.alu_wd;
        end
    end

    // Hazard check of the presented instruction against outstanding loads
    always_comb begin
        stall_s = 1'b0;
        if (SB_EN && bus.issue_valid) begin
            stall_s = reg_busy(busy_r, bus.issue_rs1) |
                      reg_busy(busy_r, bus.issue_rs2) |
                      reg_busy(busy_r, bus.issue_rd);
        end else begin
            stall_s = 1'b0;
        end
    end

    assign accept_s   = bus.issue_valid & ~stall_s;
    // A load commit frees its register; a newly accepted load claims one, winning any overlap
    assign clr_mask_s = (rf_we_r && src_lsu_r) ? (32'd1 << rf_a3_r) : 32'd0;
    assign set_mask_s = (accept_s && bus.issue_is_load && (bus.issue_rd != 5'd0))
                        ? (32'd1 << bus.issue_rd) : 32'd0;
    assign busy_nxt_s = SB_EN ? ((busy_r & ~clr_mask_s) | set_mask_s) : 32'd0;

    // Arbitration pointer, write output register and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r     <= LSU_FIRST;
            rf_we_r   <= 1'b0;
            rf_a3_r   <= 5'd0;
            rf_wd3_r  <= 32'd0;
            src_lsu_r <= 1'b0;
            busy_r    <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
            if (gnt_alu_s || gnt_lsu_s) begin
                ptr_r     <= gnt_alu_s;
                rf_we_r   <= (win_rd_s != 5'd0);
                rf_a3_r   <= win_rd_s;
                rf_wd3_r  <= win_wd_s;
                src_lsu_r <= gnt_lsu_s;
            end else begin
                rf_we_r   <= 1'b0;
                src_lsu_r <= 1'b0;
            end
        end
    end

    assign bus.alu_ready   = gnt_alu_s;
    assign bus.lsu_ready   = gnt_lsu_s;
    assign bus.issue_stall = stall_s;
    assign bus.rf_we       = rf_we_r;
    assign bus.rf_a3       = rf_a3_r;
    assign bus.rf_wd3      = rf_wd3_r;

endmodule
